// File: rtl/mix_columns_engine_if.sv
// Handshake bundle for mix_columns_engine: block-in channel, result-out channel and busy status.
// The engine connects through the slave modport; the upstream/downstream side uses master.
interface mix_columns_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, inverse, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, inverse, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine, transforming COLS_PER_CYCLE columns per clock.
// Column c of the state is bytes 4c..4c+3, with byte 0 in bits [127:120].
module mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter int unsigned OUT_REG        = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mix_columns_engine_if.slave bus
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (OUT_REG != 1) begin : gBadOutReg
        $error("mix_columns_engine: only OUT_REG = 1 is supported");
    end

    localparam int unsigned NumGroups = (COLS_PER_CYCLE == 0) ? 1 : 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LastGrp   = 2'(NumGroups - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state;
    logic [1:0]       grpCnt;
    logic [3:0][31:0] srcReg;   // srcReg[3] is column 0
    logic [3:0][31:0] resReg;
    logic [3:0][31:0] resNext;
    logic             modeReg;
    logic [127:0]     outReg;
    logic             outValid;
    logic             busyReg;
    logic             inReady;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixCol(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  y;
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                // 0E, 0B, 0D, 09 multiples from the doubling chain
                y = (x8[r] ^ x4[r] ^ x2[r])
                  ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                  ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                  ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                y = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
            res[31-8*r -: 8] = y;
        end
        return res;
    endfunction

    // Only the current group's columns are recomputed; the rest of the result holds.
    always_comb begin
        resNext = resReg;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            logic [1:0] colIdx;
            colIdx = 2'(32'(grpCnt) * COLS_PER_CYCLE + k);
            resNext[~colIdx] = mixCol(srcReg[~colIdx], modeReg);
        end
    end

    assign inReady = rst_n & ((state == StIdle) | ((state == StDone) & bus.out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            grpCnt   <= '0;
            srcReg   <= '0;
            modeReg  <= 1'b0;
            resReg   <= '0;
            outReg   <= '0;
            outValid <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        srcReg  <= bus.state_in;
                        modeReg <= bus.inverse;
                        grpCnt  <= '0;
                        busyReg <= 1'b1;
                        state   <= StBusy;
                    end
                end
                StBusy: begin
                    resReg <= resNext;
                    grpCnt <= grpCnt + 2'd1;
                    if (grpCnt == LastGrp) begin
                        outReg   <= resNext;
                        outValid <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        if (bus.in_valid) begin
                            srcReg  <= bus.state_in;
                            modeReg <= bus.inverse;
                            grpCnt  <= '0;
                            state   <= StBusy;
                        end else begin
                            busyReg <= 1'b0;
                            state   <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.state_out = outReg;
    assign bus.busy      = busyReg;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2 and 4 columns per cycle) driven in lockstep
// from a table of known MixColumns/InvMixColumns vectors plus back-pressure, reset and mode cases.
module tb_mix_columns_engine;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         modeIn = 1'b0;
    logic         outReady = 1'b0;
    logic [127:0] stateIn = '0;

    logic [2:0]   inReadyV;
    logic [2:0]   outValidV;
    logic [2:0]   busyV;
    logic [127:0] stateOutV [3];

    int nTests = 0;
    int nFail  = 0;
    int latExp [3] = '{4, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        mix_columns_engine_if bus ();
        assign bus.in_valid  = inValid;
        assign bus.state_in  = stateIn;
        assign bus.inverse   = modeIn;
        assign bus.out_ready = outReady;
        assign inReadyV[g]   = bus.in_ready;
        assign outValidV[g]  = bus.out_valid;
        assign busyV[g]      = bus.busy;
        assign stateOutV[g]  = bus.state_out;

        mix_columns_engine #(
            .COLS_PER_CYCLE((g == 2) ? 4 : g + 1),
            .OUT_REG       (1)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         mode;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic handshake(input logic [127:0] blk, input logic mode);
        for (int i = 0; i < 3; i++) chk("in_ready_before", i, 128'(inReadyV[i]), 128'(1));
        inValid = 1'b1;
        stateIn = blk;
        modeIn  = mode;
        @(posedge clk);
        #1;
        // Scramble inputs right after the handshake; the block in flight must ignore them.
        inValid = 1'b0;
        stateIn = ~blk;
        modeIn  = ~mode;
        for (int i = 0; i < 3; i++) begin
            chk("busy_after_hs", i, 128'(busyV[i]), 128'(1));
            chk("out_valid_after_hs", i, 128'(outValidV[i]), 128'(0));
        end
    endtask

    task automatic waitResult(input string name, input logic [127:0] exp);
        int lat [3];
        lat = '{0, 0, 0};
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (outValidV[i] && lat[i] == 0) lat[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            chk({name, "_latency"}, i, 128'(lat[i]), 128'(latExp[i]));
            chk({name, "_out_valid_held"}, i, 128'(outValidV[i]), 128'(1));
            chk(name, i, stateOutV[i], exp);
        end
    endtask

    task automatic releaseOut();
        outReady = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("in_ready_done_ready", i, 128'(inReadyV[i]), 128'(1));
        @(posedge clk);
        #1;
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("out_valid_after_take", i, 128'(outValidV[i]), 128'(0));
            chk("busy_after_take", i, 128'(busyV[i]), 128'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rnd;
        logic [127:0] fwd;

        vecs[0] = '{"fwd_col0", 128'hdb135345_01010101_01010101_01010101, 1'b0,
                    128'h8e4da1bc_01010101_01010101_01010101};
        vecs[1] = '{"fwd_col3", 128'h01010101_01010101_01010101_db135345, 1'b0,
                    128'h01010101_01010101_01010101_8e4da1bc};
        vecs[2] = '{"fwd_full", 128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0,
                    128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8};
        vecs[3] = '{"inv_full", 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
                    128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        vecs[4] = '{"inv_col1", 128'h01010101_8e4da1bc_01010101_01010101, 1'b1,
                    128'h01010101_db135345_01010101_01010101};
        vecs[5] = '{"fwd_zero", 128'h0, 1'b0, 128'h0};
        vecs[6] = '{"inv_perm", 128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_9fdc589d, 1'b1,
                    128'hc6c6c6c6_d4d4d4d5_2d26314c_f20a225c};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", i, 128'(outValidV[i]), 128'(0));
            chk("rst_state_out", i, stateOutV[i], 128'h0);
            chk("rst_busy", i, 128'(busyV[i]), 128'(0));
            chk("rst_in_ready", i, 128'(inReadyV[i]), 128'(0));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            handshake(vecs[v].din, vecs[v].mode);
            waitResult(vecs[v].name, vecs[v].dout);
            releaseOut();
        end

        // Random forward then inverse must give the original back
        rnd = {$urandom, $urandom, $urandom, $urandom};
        handshake(rnd, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        fwd = stateOutV[0];
        releaseOut();
        handshake(fwd, 1'b1);
        waitResult("round_trip", rnd);
        releaseOut();

        // Back-pressure: result held, nothing accepted while out_ready is low
        handshake(vecs[2].din, 1'b0);
        waitResult("bp_first", vecs[2].dout);
        for (int c = 0; c < 10; c++) begin
            inValid = 1'b1;
            stateIn = {$urandom, $urandom, $urandom, $urandom};
            modeIn  = c[0];
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk("bp_state_out", i, stateOutV[i], vecs[2].dout);
                chk("bp_in_ready", i, 128'(inReadyV[i]), 128'(0));
                chk("bp_out_valid", i, 128'(outValidV[i]), 128'(1));
            end
        end
        stateIn  = vecs[3].din;
        modeIn   = 1'b1;
        outReady = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("bp_in_ready_release", i, 128'(inReadyV[i]), 128'(1));
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        outReady = 1'b0;
        stateIn  = '0;
        modeIn   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_out_valid", i, 128'(outValidV[i]), 128'(0));
            chk("b2b_busy", i, 128'(busyV[i]), 128'(1));
        end
        waitResult("bp_second", vecs[3].dout);
        releaseOut();

        // Reset two cycles into a block
        handshake(vecs[0].din, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_out_valid", i, 128'(outValidV[i]), 128'(0));
            chk("midrst_state_out", i, stateOutV[i], 128'h0);
            chk("midrst_busy", i, 128'(busyV[i]), 128'(0));
            chk("midrst_in_ready", i, 128'(inReadyV[i]), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        handshake(vecs[2].din, 1'b0);
        waitResult("after_reset", vecs[2].dout);
        releaseOut();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning the number of state columns transformed per clock; legal values are 1, 2 and 4, and any other value SHALL be an elaboration error.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 means state_out comes from a register, 0 is reserved and SHALL be an elaboration error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: state_in and inverse are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine accepts a block this cycle.
REQ-007 SHALL have port state_in, input, 128 bits: AES state; bits [127:120] = byte 0; column c = bytes 4c..4c+3, row 0 first.
REQ-008 SHALL have port inverse, input, 1 bit: 0 = MixColumns, 1 = InvMixColumns; sampled only on input handshake.
REQ-009 SHALL have port out_valid, output, 1 bit: state_out holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream block takes the result.
REQ-011 SHALL have port state_out, output, 128 bits: transformed state, same byte order as state_in.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE: in_ready=1; in_valid=1 SHALL latch state_in into the source register and inverse into the mode register, clear grp_cnt and go to BUSY.
REQ-015 In BUSY, each cycle SHALL transform columns grp_cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 of the source register into the matching columns of the result register, then increment grp_cnt.
REQ-016 After the last group (grp_cnt = 4/COLS_PER_CYCLE-1), BUSY SHALL go to DONE.
REQ-017 Latency SHALL be exactly 4/COLS_PER_CYCLE cycles from the input-handshake edge to the first cycle with out_valid=1 (4, 2 or 1).
REQ-018 In DONE: out_valid=1 and state_out stable; the FSM stays in DONE until out_ready=1.
REQ-019 In DONE with out_ready=1: in_ready=1 (combinational from out_ready); in_valid=1 in the same cycle SHALL accept the new block and go straight to BUSY, otherwise the FSM goes to IDLE.
REQ-020 Forward mode: each column output row r = 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3] (indices mod 4), in GF(2^8) with polynomial 0x11B.
REQ-021 Inverse mode: each column output row r = 0E*a[r] ^ 0B*a[r+1] ^ 0D*a[r+2] ^ 09*a[r+3], built from xtime chains with no lookup tables.
REQ-022 in_ready SHALL be 0 in BUSY, and 0 in DONE when out_ready=0; in_valid in those cycles SHALL be ignored and state_in not sampled.
REQ-023 Changes to state_in or inverse after the handshake SHALL NOT affect the block in flight.
REQ-024 out_valid SHALL be 0 in IDLE and BUSY; state_out SHALL hold its last value outside DONE.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force the FSM to IDLE, clear grp_cnt, the source, mode and result registers, and set out_valid=0, busy=0, state_out=0; in_ready SHALL read 1 only after rst_n=1.
REQ-026 Reset during BUSY or DONE SHALL discard the in-flight block; after release the first handshake starts a fresh block.

Verification
REQ-027 Forward, COLS_PER_CYCLE=1: column db 13 53 45 (other columns 01 01 01 01) -> db→8e 4d a1 bc; the other columns unchanged; out_valid exactly 4 cycles after the handshake.
REQ-028 Forward, COLS_PER_CYCLE=4: columns f2 0a 22 5c | c6 c6 c6 c6 | d4 d4 d4 d5 | 2d 26 31 4c -> 9f dc 58 9d | c6 c6 c6 c6 | d5 d5 d7 d6 | 4d 7e bd f8; latency 1.
REQ-029 Inverse, each COLS_PER_CYCLE value: 8e 4d a1 bc | 9f dc 58 9d | d5 d5 d7 d6 | 4d 7e bd f8 -> db 13 53 45 | f2 0a 22 5c | d4 d4 d4 d5 | 2d 26 31 4c; a random forward→inverse round trip returns the original state.
REQ-030 Back-pressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a changing state_in -> state_out stable, in_ready=0, no second acceptance; then out_ready=1 with in_valid=1 -> back-to-back acceptance and a new result after the latency.
REQ-031 Reset mid-BUSY (COLS_PER_CYCLE=1, cycle 2) -> out_valid=0, state_out=0 immediately; the next block produces the correct result.
REQ-032 Mode latch: toggle inverse one cycle after the handshake -> the result still uses the mode captured at the handshake.
